// File: rtl/link_tx_arbiter.sv
// link_tx_arbiter: round-robin packet arbiter between the position and event requesters
// feeding one valid/ready byte link, with an idle gap after each packet.
module link_tx_arbiter #(
    parameter logic [7:0] HDR_POS    = 8'hA1,
    parameter logic [7:0] HDR_EVT    = 8'hE1,
    parameter int         GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pos_req,
    input  logic [11:0] pos_xpos,
    input  logic [11:0] pos_ypos,
    output logic        pos_ack,
    input  logic        evt_req,
    input  logic [7:0]  evt_code,
    output logic        evt_ack,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;
    logic [1:0]      state, idx;
    logic [15:0]     gap_cnt;
    logic            last_pos, pkt_pos, pick_pos, last_byte;
    logic [3:0][7:0] pkt;
    always_comb begin
        pick_pos  = pos_req && (!evt_req || !last_pos);
        last_byte = idx == (pkt_pos ? 2'd3 : 2'd1);
        tx_valid  = state == SEND;
        tx_data   = tx_valid ? pkt[idx] : 8'h00;
        busy      = state != IDLE;
    end
    // pkt[0] is the header; bytes leave in index order
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            gap_cnt  <= 16'd0;
            last_pos <= 1'b1;
            pkt_pos  <= 1'b0;
            pkt      <= '0;
            pos_ack  <= 1'b0;
            evt_ack  <= 1'b0;
        end else begin
            pos_ack <= 1'b0;
            evt_ack <= 1'b0;
            case (state)
                IDLE: if (pos_req || evt_req) begin
                    state    <= SEND;
                    idx      <= 2'd0;
                    last_pos <= pick_pos;
                    pkt_pos  <= pick_pos;
                    pos_ack  <= pick_pos;
                    evt_ack  <= !pick_pos;
                    pkt      <= pick_pos
                        ? {pos_ypos[7:0], pos_xpos[7:0], pos_xpos[11:8], pos_ypos[11:8], HDR_POS}
                        : {16'h0000, evt_code, HDR_EVT};
                end
                SEND: if (tx_ready) begin
                    idx <= last_byte ? 2'd0 : idx + 2'd1;
                    if (last_byte) state <= (GAP_CYCLES > 0) ? GAP : IDLE;
                end
                GAP: begin
                    gap_cnt <= (gap_cnt == 16'(GAP_CYCLES - 1)) ? 16'd0 : gap_cnt + 16'd1;
                    if (gap_cnt == 16'(GAP_CYCLES - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_link_tx_arbiter.sv
// tb_link_tx_arbiter: directed scenario tests for link_tx_arbiter with GAP_CYCLES = 16.
module tb_link_tx_arbiter;
    logic        clk, rst, pos_req, pos_ack, evt_req, evt_ack, tx_valid, tx_ready, busy;
    logic [11:0] pos_xpos, pos_ypos;
    logic [7:0]  evt_code, tx_data;
    int          checks = 0, passed = 0;
    logic [7:0]  cap [0:7];
    int          nb, busy_n, gap_n, pos_n, evt_n, hold_n, both_n;

    link_tx_arbiter #(.HDR_POS(8'hA1), .HDR_EVT(8'hE1), .GAP_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .pos_req(pos_req), .pos_xpos(pos_xpos), .pos_ypos(pos_ypos),
        .pos_ack(pos_ack), .evt_req(evt_req), .evt_code(evt_code), .evt_ack(evt_ack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grants on the next edge, then follows the packet until busy drops, logging accepted bytes.
    task automatic run(input bit drop, input int stall_byte, input int stall_len, input bit mutate);
        int left = stall_len;
        nb = 0; busy_n = 0; gap_n = 0; pos_n = 0; evt_n = 0; hold_n = 0; both_n = 0;
        step();
        for (int c = 0; c < 200 && busy; c++) begin
            busy_n++;
            if (pos_ack && evt_ack) both_n++;
            if (pos_ack) begin
                pos_n++;
                if (drop) pos_req = 1'b0;
                if (mutate) pos_xpos = 12'hFFF;
            end
            if (evt_ack) begin
                evt_n++;
                if (drop) evt_req = 1'b0;
            end
            if (!tx_valid) gap_n++;
            tx_ready = !(tx_valid && nb == stall_byte && left > 0);
            if (!tx_ready) begin
                left--;
                if (tx_data == 8'h31) hold_n++;
            end
            if (tx_valid && tx_ready && nb < 8) begin
                cap[nb] = tx_data;
                nb++;
            end
            step();
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pos_req = 1'b0; evt_req = 1'b0; tx_ready = 1'b1;
        pos_xpos = 12'h0; pos_ypos = 12'h0; evt_code = 8'h0;
        step(); step();
        checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", tx_valid); else passed++;
        checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h exp 00", tx_data); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        checks++; if ({pos_ack, evt_ack} !== 2'b00) $display("FAIL reset_acks got %b exp 00", {pos_ack, evt_ack}); else passed++;
        rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL idle_no_req_busy got %b exp 0", busy); else passed++;
    endtask

    task automatic test_single_event();
        evt_req = 1'b1; evt_code = 8'h02;
        run(1'b1, -1, 0, 1'b0);
        checks++; if (nb !== 2) $display("FAIL evt_nbytes got %0d exp 2", nb); else passed++;
        checks++; if (cap[0] !== 8'hE1) $display("FAIL evt_byte0 got %h exp e1", cap[0]); else passed++;
        checks++; if (cap[1] !== 8'h02) $display("FAIL evt_byte1 got %h exp 02", cap[1]); else passed++;
        checks++; if (evt_n !== 1 || pos_n !== 0) $display("FAIL evt_acks got evt=%0d pos=%0d exp 1/0", evt_n, pos_n); else passed++;
        checks++; if (busy_n !== 18) $display("FAIL evt_busy_cycles got %0d exp 18", busy_n); else passed++;
        checks++; if (gap_n !== 16) $display("FAIL evt_gap got %0d exp 16", gap_n); else passed++;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL evt_idle_after got %b exp 0", busy); else passed++;
    endtask

    task automatic test_position(input int stall_len, input bit mutate);
        logic [7:0] exp [4] = '{8'hA1, 8'h31, 8'hD4, 8'hA7};
        pos_req = 1'b1; pos_xpos = 12'h3D4; pos_ypos = 12'h1A7;
        run(1'b1, 1, stall_len, mutate);
        checks++; if (nb !== 4) $display("FAIL pos_nbytes[stall=%0d] got %0d exp 4", stall_len, nb); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (cap[i] !== exp[i]) $display("FAIL pos_byte%0d[stall=%0d mut=%0d] got %h exp %h", i, stall_len, mutate, cap[i], exp[i]); else passed++;
        end
        checks++; if (pos_n !== 1 || evt_n !== 0) $display("FAIL pos_acks got pos=%0d evt=%0d exp 1/0", pos_n, evt_n); else passed++;
        checks++; if (hold_n !== stall_len) $display("FAIL pos_hold got %0d exp %0d", hold_n, stall_len); else passed++;
        checks++; if (busy_n !== 20 + stall_len) $display("FAIL pos_busy_cycles got %0d exp %0d", busy_n, 20 + stall_len); else passed++;
        pos_xpos = 12'h3D4;
        step();
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        step();
        rst = 1'b0; pos_req = 1'b1; evt_req = 1'b1;
        pos_xpos = 12'h3D4; pos_ypos = 12'h1A7; evt_code = 8'h02;
        for (int k = 0; k < 4; k++) begin
            run(1'b0, -1, 0, 1'b0);
            checks++; if (evt_n !== ((k % 2 == 0) ? 1 : 0) || pos_n !== ((k % 2 == 1) ? 1 : 0))
                $display("FAIL rr_order pkt%0d got evt=%0d pos=%0d", k, evt_n, pos_n); else passed++;
            checks++; if (cap[0] !== ((k % 2 == 0) ? 8'hE1 : 8'hA1)) $display("FAIL rr_header pkt%0d got %h", k, cap[0]); else passed++;
            checks++; if (gap_n !== 16) $display("FAIL rr_gap pkt%0d got %0d exp 16", k, gap_n); else passed++;
            checks++; if (both_n !== 0) $display("FAIL rr_both_acks pkt%0d got %0d exp 0", k, both_n); else passed++;
        end
        pos_req = 1'b0; evt_req = 1'b0;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL rr_idle_after got %b exp 0", busy); else passed++;
    endtask

    task automatic test_reset_mid_packet();
        pos_req = 1'b1; pos_xpos = 12'h3D4; pos_ypos = 12'h1A7; tx_ready = 1'b0;
        step();
        tx_ready = 1'b1;
        step();
        checks++; if (tx_data !== 8'h31 || tx_valid !== 1'b1) $display("FAIL mid_byte1 got %h/%b exp 31/1", tx_data, tx_valid); else passed++;
        tx_ready = 1'b0; evt_req = 1'b1; rst = 1'b1;
        step();
        checks++; if (tx_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", tx_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", busy); else passed++;
        rst = 1'b0;
        step();
        checks++; if (evt_ack !== 1'b1 || pos_ack !== 1'b0) $display("FAIL mid_regrant got evt=%b pos=%b exp 1/0", evt_ack, pos_ack); else passed++;
        checks++; if (tx_data !== 8'hE1) $display("FAIL mid_regrant_hdr got %h exp e1", tx_data); else passed++;
        pos_req = 1'b0; evt_req = 1'b0; tx_ready = 1'b1;
        for (int c = 0; c < 100 && busy; c++) step();
        checks++; if (busy !== 1'b0) $display("FAIL mid_drain got %b exp 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_position(0, 1'b0);
        test_position(5, 1'b0);
        test_position(0, 1'b1);
        test_simultaneous();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
